// File: rtl/rf_pkg.sv
// Shared register-file constants and types used by the read-port arbiter and its clients.
package rf_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 64;

   typedef logic [ADDR_W-1:0] rf_addr_t;
   typedef logic [DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4
)(
   input  logic [N-1:0]                         req,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
   input  logic                                 enable,
   output logic [N-1:0]                         grant,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic found;
   int   pos;

   // Scan N positions starting at ptr; the first hit wins so the grant stays one-hot.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (enable && !found && req[pos]) begin
            grant[pos] = 1'b1;
            grant_idx  = IW'(pos);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_read_arbiter.sv
// Shares one register-file read mux among NUM_REQ clients: arbitrate, drive the select from S1,
// capture the mux output into S2 and return it tagged with the requester id.
module rf_read_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = rf_pkg::ADDR_W,
   parameter int DATA_W  = rf_pkg::DATA_W
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [ADDR_W-1:0]             rd_sel,
   input  logic [DATA_W-1:0]             rd_data,
   output logic                          resp_valid,
   output logic [$clog2(NUM_REQ)-1:0]    resp_id,
   output logic [DATA_W-1:0]             resp_data,
   input  logic                          resp_ready
);

   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0]     ptr_q,    ptr_d;
   logic               s1V_q,    s1V_d;
   logic [ADDR_W-1:0]  s1Addr_q, s1Addr_d;
   logic [IDW-1:0]     s1Id_q,   s1Id_d;
   logic               s2V_q,    s2V_d;
   logic [DATA_W-1:0]  s2Data_q, s2Data_d;
   logic [IDW-1:0]     s2Id_q,   s2Id_d;

   logic               stall;
   logic               anyGrant;
   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     grantIdx;

   assign stall    = s2V_q & ~resp_ready;
   assign anyGrant = |grant;

   // Reset also gates the grant so no handshake can complete while state is being cleared.
   rr_arbiter #(.N(NUM_REQ)) uArb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .enable    (~stall & ~reset),
      .grant     (grant),
      .grant_idx (grantIdx)
   );

   assign req_ready  = grant;
   assign rd_sel     = s1Addr_q;
   assign resp_valid = s2V_q;
   assign resp_id    = s2Id_q;
   assign resp_data  = s2Data_q;

   // The whole pipeline advances together; under stall everything holds so rd_sel keeps rd_data valid.
   always_comb begin
      ptr_d    = ptr_q;
      s1V_d    = s1V_q;
      s1Addr_d = s1Addr_q;
      s1Id_d   = s1Id_q;
      s2V_d    = s2V_q;
      s2Data_d = s2Data_q;
      s2Id_d   = s2Id_q;
      if (!stall) begin
         s2V_d    = s1V_q;
         s2Data_d = s1V_q ? rd_data : '0;
         s2Id_d   = s1Id_q;
         s1V_d    = anyGrant;
         s1Addr_d = anyGrant ? req_addr[int'(grantIdx)*ADDR_W +: ADDR_W] : '0;
         s1Id_d   = anyGrant ? grantIdx : '0;
         if (anyGrant) begin
            ptr_d = (int'(grantIdx) == NUM_REQ-1) ? '0 : grantIdx + IDW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q    <= '0;
         s1V_q    <= 1'b0;
         s1Addr_q <= '0;
         s1Id_q   <= '0;
         s2V_q    <= 1'b0;
         s2Data_q <= '0;
         s2Id_q   <= '0;
      end else begin
         ptr_q    <= ptr_d;
         s1V_q    <= s1V_d;
         s1Addr_q <= s1Addr_d;
         s1Id_q   <= s1Id_d;
         s2V_q    <= s2V_d;
         s2Data_q <= s2Data_d;
         s2Id_q   <= s2Id_d;
      end
   end

endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
- Round-robin arbiter that shares the single 32x64 register-file read mux among NUM_REQ requesters.
- Each requester issues a 5-bit register address through a valid/ready handshake.
- The block drives the mux select from a registered stage, captures the mux output, and returns it on a tagged response channel with backpressure.
- Sits between the pipeline read clients and the regfile read-mux tree.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 64, register data width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- rd_sel  output  ADDR_W  select to shared read mux.
- rd_data  input  DATA_W  combinational mux output for rd_sel.
- resp_valid  output  1  response data valid.
- resp_id  output  $clog2(NUM_REQ)  index of requester owning the response.
- resp_data  output  DATA_W  captured register value.
- resp_ready  input  1  response consumer ready.

Behaviour:
- Reset values:
  - req_ready = 0, rd_sel = 0, resp_valid = 0, resp_id = 0, resp_data = 0.
  - Round-robin pointer ptr = 0; stage valids s1_v = s2_v = 0.
- Two-stage pipeline:
  - S1 holds {addr, id}; rd_sel = S1 addr (registered, 0 when S1 empty).
  - S2 holds {data, id}; it drives resp_*.
- stall = s2_v & ~resp_ready.
- Arbitration, combinational:
  - When ~stall, grant the first i with req_valid[i], scanning from ptr upward with wrap modulo NUM_REQ.
  - At most one req_ready bit high.
  - When stall, req_ready = 0.
  - req_ready never depends on a request from the same cycle being accepted elsewhere.
- On each edge when ~stall:
  - S2 <= {rd_data, S1 id}, s2_v <= s1_v.
  - S1 <= granted {addr, id}, s1_v <= (grant != 0).
  - If granted requester is g, ptr <= (g+1) mod NUM_REQ; ptr is unchanged when there is no grant.
- On each edge when stall: S1, S2 and ptr all hold; rd_sel stays stable, so rd_data remains valid for the held S1.
- Latency: handshake in cycle N gives resp_valid in cycle N+2 when there is no stall. Throughput is 1 response/cycle.
- resp_* is stable while resp_valid & ~resp_ready.
- A response is consumed when resp_valid & resp_ready; S2 is refilled the same edge if S1 is valid.
- Simultaneous consume and new grant in the same cycle is allowed; there are no bubbles.
- No requests: pipeline drains, resp_valid drops after the last response, rd_sel returns to 0 once S1 is empty.
- Pointer fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Requests are not queued internally. An ungranted requester must hold req_valid/addr; the arbiter treats a dropped request as withdrawn.
- Reset asserted mid-operation: in-flight S1/S2 contents are discarded, no response is emitted, and ptr returns to 0. The first grant after reset release goes to the lowest-index valid requester.
- Address 31 is treated as an ordinary register; zero-register semantics belong to the regfile, not this block.

Decomposition:
- Shared package rf_pkg holds:
  - localparams NUM_REGS=32, ADDR_W=5, DATA_W=64.
  - typedef rf_addr_t (logic [4:0]) and rf_data_t (logic [63:0]).
- One sub-module: rr_arbiter (parameter N).
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; ptr register stays in the parent.
- The pipeline registers live in rf_read_arbiter.

Test Plan:
- Bench model: rd_data = 64'h1000 + rd_sel; resp_ready = 1 unless stated.
- Single request: cycle 0 req_valid=4'b0001, addr0=5 -> req_ready=4'b0001 in cycle 0; rd_sel=5 in cycle 1; resp_valid=1, resp_id=0, resp_data=64'h1005 in cycle 2.
- Round-robin: all four valid continuously, addr_i=i+10 -> grants in order 0,1,2,3,0; responses 64'h100A, 100B, 100C, 100D, 100A, one per cycle, ids 0,1,2,3,0.
- Backpressure: two back-to-back requests (ids 1, 2), resp_ready=0 for cycles 2-4:
  - resp_data holds 64'h1000+addr1 and rd_sel holds addr2 throughout; req_ready=0 throughout.
  - After resp_ready=1, both responses are delivered in order with no loss.
- Pointer wrap: ptr=3 after granting 2; requests from 0 and 3 -> 3 granted first, then 0.
- Reset mid-flight: assert reset in cycle 1 after a grant -> resp_valid stays 0, rd_sel=0 immediately. After release, requests 2 and 1 -> 1 granted first.
- Idle drain: single request then none -> exactly one resp_valid pulse, and rd_sel=0 from cycle 2 on.
